// File: rtl/if_id_stage.sv
// ---------------------------------------------------------------------------
// if_id_stage
//
// Fetch-to-decode pipeline stage of the LC-3b pipeline. Issues instruction
// memory reads at the current PC, captures the returned word together with
// its incremented PC in the IF/ID register, and drives the decode control
// ROM taps (opcode/ir11/ir5/ir4) straight from that register.
//
// Stalls are absorbed by a one-entry skid buffer: a word that returns while
// decode is held is parked there and handed to IF/ID when the stall drops.
// Flushes squash IF/ID, the skid buffer, and any fetch still in flight.
//
// Ports
//   clk           in   clock
//   rst           in   synchronous, active-high reset
//   fetch_pc      in   PC register value (address of the word being fetched)
//   imem_rdata    in   instruction memory read data
//   imem_resp     in   memory response, meaningful only while imem_read=1
//   stall         in   hazard unit: hold IF/ID contents
//   flush         in   taken branch/jump/trap: squash IF/ID and fetch
//   imem_read     out  read request, held until imem_resp
//   imem_address  out  equals fetch_pc
//   pc_advance    out  one-cycle pulse: PC register loads fetch_pc+PC_INC
//   id_valid      out  IF/ID holds a real instruction
//   id_ir         out  IF/ID instruction
//   id_pc         out  PC+PC_INC of id_ir
//   opcode        out  id_ir[15:12]
//   ir11/ir5/ir4  out  id_ir[11], id_ir[5], id_ir[4]
//
// Handshake: imem_read acts as "valid" for the request and imem_resp as its
// completion. The request is raised whenever the skid buffer is empty and is
// held, with imem_address stable from the PC register, until imem_resp is
// seen high in the same cycle; that cycle is the transfer. imem_resp in a
// cycle with imem_read low is not a transfer and is ignored.
// ---------------------------------------------------------------------------
module if_id_stage #(
  parameter int                 WIDTH    = 16,
  parameter int                 PC_INC   = 2,
  parameter logic [WIDTH-1:0]   NOP_WORD = 16'h0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] fetch_pc,
  input  logic [WIDTH-1:0] imem_rdata,
  input  logic             imem_resp,
  input  logic             stall,
  input  logic             flush,
  output logic             imem_read,
  output logic [WIDTH-1:0] imem_address,
  output logic             pc_advance,
  output logic             id_valid,
  output logic [WIDTH-1:0] id_ir,
  output logic [WIDTH-1:0] id_pc,
  output logic [3:0]       opcode,
  output logic             ir11,
  output logic             ir5,
  output logic             ir4
);

  localparam logic [WIDTH-1:0] PC_INC_W = WIDTH'(PC_INC);

  // All architectural state of the stage, grouped so a checker can bind to
  // a single signal.
  typedef struct packed {
    logic             id_valid;
    logic [WIDTH-1:0] id_ir;
    logic [WIDTH-1:0] id_pc;
    logic             buf_valid;
    logic [WIDTH-1:0] buf_ir;
    logic [WIDTH-1:0] buf_pc;
    logic             discard;
  } stage_state_t;

  stage_state_t     state_q;
  stage_state_t     state_d;

  logic             accept;
  logic [WIDTH-1:0] cap_pc;

  // -------------------------------------------------------------------------
  // Request side
  // -------------------------------------------------------------------------
  // A full skid buffer means decode is still stalled on an instruction we
  // already hold, so there is nowhere to put another word: stop fetching.
  assign imem_read    = ~state_q.buf_valid;
  assign imem_address = fetch_pc;

  // A response is only taken when it belongs to the current (non-squashed)
  // request and no redirect is happening this very cycle.
  assign accept     = imem_read & imem_resp & ~state_q.discard & ~flush;
  assign pc_advance = accept;

  // Wraps modulo 2^WIDTH (0xFFFE + 2 -> 0x0000).
  assign cap_pc = fetch_pc + PC_INC_W;

  // -------------------------------------------------------------------------
  // Next-state logic, priority flush > stall > normal (rst handled in the
  // register process).
  // -------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;

    if (flush) begin
      state_d.id_valid  = 1'b0;
      state_d.id_ir     = NOP_WORD;
      state_d.buf_valid = 1'b0;
      // A request still outstanding at the moment of the flush will return
      // a wrong-path word later; remember to throw it away. A response that
      // lands in the flush cycle itself completes the old request, so no
      // marker is needed for it.
      state_d.discard   = imem_read & ~imem_resp;
    end else begin
      // The squashed response finally arrived: it is dropped (accept is low
      // because discard is set) and the next request is a fresh one.
      if (state_q.discard && imem_read && imem_resp) begin
        state_d.discard = 1'b0;
      end

      if (stall) begin
        // IF/ID holds; a word arriving now is parked in the skid buffer.
        if (accept) begin
          state_d.buf_valid = 1'b1;
          state_d.buf_ir    = imem_rdata;
          state_d.buf_pc    = cap_pc;
        end
      end else if (state_q.buf_valid) begin
        // imem_read is low here, so no response can compete with the
        // buffered word.
        state_d.id_valid  = 1'b1;
        state_d.id_ir     = state_q.buf_ir;
        state_d.id_pc     = state_q.buf_pc;
        state_d.buf_valid = 1'b0;
      end else if (accept) begin
        state_d.id_valid = 1'b1;
        state_d.id_ir    = imem_rdata;
        state_d.id_pc    = cap_pc;
      end else begin
        // Nothing arrived: insert a bubble. id_pc is left as-is since it is
        // meaningless while id_valid is low.
        state_d.id_valid = 1'b0;
        state_d.id_ir    = NOP_WORD;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q.id_valid  <= 1'b0;
      state_q.id_ir     <= NOP_WORD;
      state_q.id_pc     <= '0;
      state_q.buf_valid <= 1'b0;
      state_q.buf_ir    <= NOP_WORD;
      state_q.buf_pc    <= '0;
      state_q.discard   <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  // -------------------------------------------------------------------------
  // IF/ID outputs and decode taps. id_ir is forced to NOP_WORD whenever the
  // stage is empty, so the taps read a harmless BR-never pattern then.
  // -------------------------------------------------------------------------
  assign id_valid = state_q.id_valid;
  assign id_ir    = state_q.id_ir;
  assign id_pc    = state_q.id_pc;

  assign opcode   = state_q.id_ir[15:12];
  assign ir11     = state_q.id_ir[11];
  assign ir5      = state_q.id_ir[5];
  assign ir4      = state_q.id_ir[4];

endmodule
